// File: rtl/rl_pkg.sv
// Shared reinforcement-learning definitions: action encodings, state/reward widths
// and the environment FSM state type, used by the environment, policy and accelerator stages.
package rl_pkg;

    localparam int STATE_W  = 6;
    localparam int REWARD_W = 16;
    localparam int COUNT_W  = 16;
    localparam int ACTION_W = 4;

    localparam logic [ACTION_W-1:0] ACT_UP    = 4'b0001;
    localparam logic [ACTION_W-1:0] ACT_DOWN  = 4'b0010;
    localparam logic [ACTION_W-1:0] ACT_LEFT  = 4'b0100;
    localparam logic [ACTION_W-1:0] ACT_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } env_fsm_t;

endpackage

// File: rtl/grid_move_calc.sv
// Combinational 8x8 grid move: candidate state, blocked flag and reward for one action.
// Obstacle handling is compiled in only when GRID_ENV_OBSTACLE_EN is defined.
module grid_move_calc
    import rl_pkg::*;
#(
    parameter logic [STATE_W-1:0]         GOAL_STATE  = 6'd63,
    parameter logic signed [REWARD_W-1:0] R_STEP      = -16'sd1,
    parameter logic signed [REWARD_W-1:0] R_GOAL      = 16'sd100,
    parameter logic signed [REWARD_W-1:0] R_WALL      = -16'sd5
`ifdef GRID_ENV_OBSTACLE_EN
    ,
    parameter logic [STATE_W-1:0]         START_STATE = 6'd0,
    parameter logic signed [REWARD_W-1:0] R_OBST      = -16'sd20
`endif
) (
    input  logic [STATE_W-1:0]         state,
    input  logic [ACTION_W-1:0]        action,
`ifdef GRID_ENV_OBSTACLE_EN
    input  logic [63:0]                obstacle_map,
`endif
    output logic [STATE_W-1:0]         cand_state,
    output logic                       blocked,
    output logic signed [REWARD_W-1:0] reward
);

    logic [2:0] row;
    logic [2:0] col;

    assign row = state[5:3];
    assign col = state[2:0];

    always_comb begin
        cand_state = state;
        blocked    = 1'b1;
        reward     = R_WALL;
        // Any code that is not exactly one of the four one-hot moves falls to the wall case.
        case (action)
            ACT_UP:    if (row != 3'd0) begin cand_state = {row - 3'd1, col}; blocked = 1'b0; end
            ACT_DOWN:  if (row != 3'd7) begin cand_state = {row + 3'd1, col}; blocked = 1'b0; end
            ACT_LEFT:  if (col != 3'd0) begin cand_state = {row, col - 3'd1}; blocked = 1'b0; end
            ACT_RIGHT: if (col != 3'd7) begin cand_state = {row, col + 3'd1}; blocked = 1'b0; end
            default:   ;
        endcase

        if (!blocked) begin
`ifdef GRID_ENV_OBSTACLE_EN
            if (obstacle_map[cand_state] && (cand_state != START_STATE) &&
                (cand_state != GOAL_STATE)) begin
                cand_state = state;
                blocked    = 1'b1;
                reward     = R_OBST;
            end else if (cand_state == GOAL_STATE) begin
                reward = R_GOAL;
            end else begin
                reward = R_STEP;
            end
`else
            reward = (cand_state == GOAL_STATE) ? R_GOAL : R_STEP;
`endif
        end
    end

endmodule

// File: rtl/grid_environment.sv
// 8x8 grid-world environment: accepts one-hot actions, returns next state and reward a cycle later.
// Optional obstacle map is enabled with the GRID_ENV_OBSTACLE_EN macro.
module grid_environment
    import rl_pkg::*;
#(
    parameter logic [STATE_W-1:0]         START_STATE = 6'd0,
    parameter logic [STATE_W-1:0]         GOAL_STATE  = 6'd63,
    parameter logic [COUNT_W-1:0]         MAX_STEPS   = 16'd200,
    parameter logic signed [REWARD_W-1:0] R_STEP      = -16'sd1,
    parameter logic signed [REWARD_W-1:0] R_GOAL      = 16'sd100,
    parameter logic signed [REWARD_W-1:0] R_WALL      = -16'sd5
`ifdef GRID_ENV_OBSTACLE_EN
    ,
    parameter logic signed [REWARD_W-1:0] R_OBST      = -16'sd20
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       action_valid,
    input  logic [ACTION_W-1:0]        action,
`ifdef GRID_ENV_OBSTACLE_EN
    input  logic [63:0]                obstacle_map,
`endif
    output logic                       action_ready,
    output logic                       step_valid,
    output logic [STATE_W-1:0]         next_state,
    output logic signed [REWARD_W-1:0] next_reward,
    output logic                       episode_done,
    output logic [COUNT_W-1:0]         step_count
);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    env_fsm_t                    state_q;
    env_fsm_t                    state_d;
    logic                        hs;
    logic [STATE_W-1:0]          cand_state;
    logic                        blocked;
    logic signed [REWARD_W-1:0]  move_reward;
    logic [COUNT_W-1:0]          cnt_inc;
    logic                        terminal;
    logic                        vld_p0;

    grid_move_calc #(
        .GOAL_STATE  (GOAL_STATE),
        .R_STEP      (R_STEP),
        .R_GOAL      (R_GOAL),
        .R_WALL      (R_WALL)
`ifdef GRID_ENV_OBSTACLE_EN
        ,
        .START_STATE (START_STATE),
        .R_OBST      (R_OBST)
`endif
    ) u_move (
        .state        (next_state),
        .action       (action),
`ifdef GRID_ENV_OBSTACLE_EN
        .obstacle_map (obstacle_map),
`endif
        .cand_state   (cand_state),
        .blocked      (blocked),
        .reward       (move_reward)
    );

    // start always wins over a presented action, so ready drops combinationally with it.
    assign action_ready = (state_q == ST_READY) && !start;
    assign hs           = action_valid && action_ready;
    assign cnt_inc      = sat_inc(step_count);
    assign terminal     = (!blocked && (cand_state == GOAL_STATE)) || (cnt_inc == MAX_STEPS);
    assign step_valid   = vld_p0;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_READY;
        end else begin
            case (state_q)
                ST_READY: if (hs) state_d = ST_STEP;
                ST_STEP:  state_d = episode_done ? ST_DONE : ST_READY;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result stage: the handshake edge captures the move outcome, visible with vld_p0 next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0       <= 1'b0;
            next_state   <= START_STATE;
            next_reward  <= '0;
            step_count   <= '0;
            episode_done <= 1'b0;
        end else if (start) begin
            vld_p0       <= 1'b1;
            next_state   <= START_STATE;
            next_reward  <= '0;
            step_count   <= '0;
            episode_done <= 1'b0;
        end else if (hs) begin
            vld_p0       <= 1'b1;
            next_state   <= cand_state;
            next_reward  <= move_reward;
            step_count   <= cnt_inc;
            episode_done <= terminal;
        end else begin
            vld_p0       <= 1'b0;
        end
    end

endmodule

// File: doc/grid_environment.md
GRID_ENVIRONMENT -- requirements
Module: grid_environment

Interface
REQ-001 Parameter START_STATE, default 6'd0, state index at which every episode begins.
REQ-002 Parameter GOAL_STATE, default 6'd63, terminal goal state index.
REQ-003 Parameter MAX_STEPS, default 16'd200, step limit per episode.
REQ-004 Parameter R_STEP, default -16'sd1, reward for a legal non-goal move.
REQ-005 Parameter R_GOAL, default 16'sd100, reward for entering GOAL_STATE.
REQ-006 Parameter R_WALL, default -16'sd5, reward for a move blocked by the grid edge or for an illegal action code.
REQ-007 Port clk  input  1  single clock; all logic on rising edge.
REQ-008 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 Port start  input  1  single-cycle pulse, begin or restart an episode.
REQ-010 Port action_valid  input  1  action present from policy stage.
REQ-011 Port action  input  4  one-hot move: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-012 Port action_ready  output  1  environment accepts an action this cycle.
REQ-013 Port step_valid  output  1  one-cycle pulse, next_state/next_reward updated.
REQ-014 Port next_state  output  6  state index, row = [5:3], col = [2:0], held between pulses.
REQ-015 Port next_reward  output  16  signed two's-complement reward, held between pulses.
REQ-016 Port episode_done  output  1  level, high from the terminal step until the next start.
REQ-017 Port step_count  output  16  accepted actions in the current episode.

Function
REQ-018 FSM states IDLE, READY, STEP, DONE. IDLE->READY on start; READY->STEP on action_valid&&action_ready; STEP->DONE if terminal, else STEP->READY; DONE->READY on start.
REQ-019 action_ready SHALL be high only in READY and only when start is low.
REQ-020 Handshake at cycle N SHALL register the action; the result SHALL appear with step_valid at N+1 (latency one).
REQ-021 Up/down SHALL change row by -1/+1 and left/right col by -1/+1, never wrapping; a move past an edge SHALL leave the state unchanged with reward R_WALL.
REQ-022 A non-one-hot action (zero or multiple bits) SHALL be consumed, leave the state unchanged, return R_WALL and increment step_count.
REQ-023 Entering GOAL_STATE SHALL return R_GOAL and assert episode_done; otherwise a legal move returns R_STEP.
REQ-024 When the incremented step_count equals MAX_STEPS the step SHALL be terminal with its normal reward; goal and timeout on the same step SHALL return R_GOAL.
REQ-025 step_count SHALL saturate at 16'hFFFF and never wrap.
REQ-026 start in any state SHALL load START_STATE, clear step_count and episode_done, emit step_valid next cycle with reward 0, and enter READY; an in-flight STEP result SHALL be discarded.
REQ-027 start coincident with action_valid SHALL win; the action SHALL not be accepted.

Reset
REQ-028 rst_n low SHALL force IDLE, next_state=START_STATE, next_reward=0, step_count=0, step_valid=0, episode_done=0, action_ready=0, asynchronously.
REQ-029 Reset mid-STEP SHALL discard the pending result; no step_valid SHALL follow release until a start.

Configuration
REQ-030 Macro GRID_ENV_OBSTACLE_EN SHALL add input obstacle_map [63:0] and parameter R_OBST (default -16'sd20).
REQ-031 With the macro, a move onto a state whose obstacle_map bit is set SHALL leave the state unchanged and return R_OBST; obstacle_map[START_STATE] and obstacle_map[GOAL_STATE] SHALL be ignored.
REQ-032 Without the macro, neither port nor obstacle logic SHALL exist and behaviour SHALL match REQ-021..027.

Structure
REQ-033 Package rl_pkg SHALL hold the action one-hot constants, state/reward widths, and the FSM state typedef, shared with the policy and accelerator stages.
REQ-034 Sub-module grid_move_calc SHALL be purely combinational: state and action in, candidate state, blocked flag and reward out.

Verification
REQ-035 Reset, start, action up at state 0 -> step_valid at N+1, next_state 0, reward -5, step_count 1.
REQ-036 From state 0: seven right then seven down -> final next_state 63, reward 100, episode_done 1, action_ready 0.
REQ-037 MAX_STEPS=3, three legal moves not reaching goal -> third step reward -1, episode_done 1, step_count 3.
REQ-038 action 4'b0011 at state 9 -> next_state 9, reward -5; start and action_valid same cycle -> no handshake, next_state START_STATE, reward 0.
REQ-039 With GRID_ENV_OBSTACLE_EN, obstacle_map bit 1 set, right from state 0 -> next_state 0, reward -20.
REQ-040 rst_n low during STEP -> no step_valid after release, outputs at reset values until start.
